// File: rtl/euler_pkg.sv
// Shared types and constants for the explicit-Euler step controller:
// FSM state encoding, default word widths and Q-format saturation limits.
package euler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_MUL,
        ST_UPD,
        ST_DONE
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int FRAC_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // Saturation limits for the default word width.
    localparam logic [DATA_W_DEF-1:0] FX_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] FX_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/euler_step_ctrl_if.sv
// Request/acknowledge bus between the Euler controller (master) and the
// derivative unit that evaluates f(t,y) (slave).
interface euler_step_ctrl_if
    import euler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              f_req;
    logic [DATA_W-1:0] f_t;
    logic [DATA_W-1:0] f_y;
    logic              f_ack;
    logic [DATA_W-1:0] f_val;

    modport master (
        output f_req, f_t, f_y,
        input  f_ack, f_val
    );

    modport slave (
        input  f_req, f_t, f_y,
        output f_ack, f_val
    );
endinterface

// File: rtl/euler_fx_mul.sv
// Signed Q-format multiply: full-width product, arithmetic shift (floor).
// EULER_SAT_EN defined: clamp to the signed word range; otherwise wrap.
module euler_fx_mul
    import euler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_o
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] full;
    logic signed [PW-1:0] shifted;

    assign a_ext   = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i});
    assign b_ext   = $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    assign full    = a_ext * b_ext;
    assign shifted = full >>> FRAC_W;

`ifdef EULER_SAT_EN
    localparam logic [DATA_W-1:0] MAX_W = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

    // In range only when every bit above the result sign matches it.
    always_comb begin
        p_o = shifted[DATA_W-1:0];
        if (!shifted[PW-1] && (|shifted[PW-1:DATA_W-1])) begin
            p_o = MAX_W;
        end else if (shifted[PW-1] && !(&shifted[PW-1:DATA_W-1])) begin
            p_o = MIN_W;
        end
    end
`else
    logic unused_hi;

    assign p_o       = shifted[DATA_W-1:0];
    assign unused_hi = ^shifted[PW-1:DATA_W];
`endif

endmodule

// File: rtl/euler_step_ctrl.sv
// Explicit Euler integrator sequencer: y += h*f(t,y), t += h for n_steps.
// Optional EULER_SAT_EN build macro saturates the y update instead of wrapping.
module euler_step_ctrl
    import euler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] h,
    input  logic [DATA_W-1:0] t0,
    input  logic [DATA_W-1:0] y0,
    input  logic [CNT_W-1:0]  n_steps,
    euler_step_ctrl_if.master f_bus,
    output logic [DATA_W-1:0] y_out,
    output logic [DATA_W-1:0] t_out,
    output logic              y_valid,
    output logic              busy,
    output logic              final_done
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [DATA_W-1:0] h_q, h_d;
    logic [DATA_W-1:0] t_q, t_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] fval_q, fval_d;
    logic [DATA_W-1:0] p_q, p_d;
    logic [DATA_W-1:0] y_out_q, y_out_d;
    logic [DATA_W-1:0] t_out_q, t_out_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] mul_p;
    logic [DATA_W-1:0] y_sum;
    logic [DATA_W-1:0] t_sum;

    euler_fx_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mul (
        .a_i (h_q),
        .b_i (fval_q),
        .p_o (mul_p)
    );

    assign t_sum = t_q + h_q;

`ifdef EULER_SAT_EN
    localparam logic [DATA_W-1:0] MAX_W = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_W = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] y_ext;

    // One guard bit: overflow when it disagrees with the result sign.
    assign y_ext = {y_q[DATA_W-1], y_q} + {p_q[DATA_W-1], p_q};
    always_comb begin
        y_sum = y_ext[DATA_W-1:0];
        if (y_ext[DATA_W] != y_ext[DATA_W-1]) begin
            y_sum = y_ext[DATA_W] ? MIN_W : MAX_W;
        end
    end
`else
    assign y_sum = y_q + p_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
            fval_q  <= '0;
            p_q     <= '0;
            y_out_q <= '0;
            t_out_q <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            t_q     <= t_d;
            y_q     <= y_d;
            fval_q  <= fval_d;
            p_q     <= p_d;
            y_out_q <= y_out_d;
            t_out_q <= t_out_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        t_d     = t_q;
        y_d     = y_q;
        fval_d  = fval_q;
        p_d     = p_q;
        y_out_d = y_out_q;
        t_out_d = t_out_q;
        n_d     = n_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    h_d     = h;
                    t_d     = t0;
                    y_d     = y0;
                    n_d     = n_steps;
                    cnt_d   = '0;
                    state_d = (n_steps == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (f_bus.f_ack) begin
                    fval_d  = f_bus.f_val;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                p_d     = mul_p;
                state_d = ST_UPD;
            end
            ST_UPD: begin
                y_d     = y_sum;
                t_d     = t_sum;
                y_out_d = y_sum;
                t_out_d = t_sum;
                cnt_d   = cnt_q + CNT_ONE;
                // cnt_q never exceeds n_q-1 here, so the increment cannot wrap.
                state_d = ((cnt_q + CNT_ONE) == n_q) ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign f_bus.f_req = (state_q == ST_REQ);
    assign f_bus.f_t   = t_q;
    assign f_bus.f_y   = y_q;

    // Results are forwarded during UPD so y_valid and the new value coincide.
    assign y_valid    = (state_q == ST_UPD);
    assign y_out      = (state_q == ST_UPD) ? y_sum : y_out_q;
    assign t_out      = (state_q == ST_UPD) ? t_sum : t_out_q;
    assign busy       = (state_q != ST_IDLE);
    assign final_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_euler_step_ctrl.sv
// Directed bench for euler_step_ctrl: Q16.16 vectors with hand-computed results.
// Expected values follow the EULER_SAT_EN setting of the build.
module tb_euler_step_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] h_in;
    logic [31:0] t0_in;
    logic [31:0] y0_in;
    logic [15:0] n_in;
    logic [31:0] y_out;
    logic [31:0] t_out;
    logic        y_valid;
    logic        busy;
    logic        final_done;

    int n_tests;
    int n_fail;

    euler_step_ctrl_if #(.DATA_W(32)) f_bus ();

    euler_step_ctrl #(
        .DATA_W (32),
        .FRAC_W (16),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .h          (h_in),
        .t0         (t0_in),
        .y0         (y0_in),
        .n_steps    (n_in),
        .f_bus      (f_bus),
        .y_out      (y_out),
        .t_out      (t_out),
        .y_valid    (y_valid),
        .busy       (busy),
        .final_done (final_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one start..final_done sequence; called at #1 after a rising edge.
    task automatic run_seq(input string name,
                           input logic [31:0] hv, input logic [31:0] t0v,
                           input logic [31:0] y0v, input logic [15:0] nv,
                           input int delay, input logic [31:0] fv, input bit dbl,
                           input logic [31:0] ey0, input logic [31:0] ey1,
                           input logic [31:0] ey2, input logic [31:0] et0,
                           input logic [31:0] et1, input logic [31:0] et2);
        logic [31:0] ey[3];
        logic [31:0] et[3];
        logic [31:0] ft_hold;
        logic [31:0] fy_hold;
        int yv_cnt;
        int fd_cnt;
        int fr_seen;
        int last_yv;
        int fd_cyc;
        int wait_cnt;
        int extra;
        bit dbl_done;
        ey[0] = ey0; ey[1] = ey1; ey[2] = ey2;
        et[0] = et0; et[1] = et1; et[2] = et2;
        yv_cnt = 0; fd_cnt = 0; fr_seen = 0; last_yv = -10; fd_cyc = -1;
        wait_cnt = 0; extra = 0; dbl_done = 1'b0;
        ft_hold = '0; fy_hold = '0;

        h_in = hv; t0_in = t0v; y0_in = y0v; n_in = nv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int cyc = 0; cyc < 300 && fd_cnt == 0; cyc++) begin
            if (start) begin
                start = 1'b0;
                h_in = hv; y0_in = y0v; n_in = nv;
            end
            if (f_bus.f_req) begin
                fr_seen++;
                if (wait_cnt == 0) begin
                    ft_hold = f_bus.f_t;
                    fy_hold = f_bus.f_y;
                end else begin
                    check({name, " f_t stable"}, f_bus.f_t, ft_hold);
                    check({name, " f_y stable"}, f_bus.f_y, fy_hold);
                end
                if (dbl && !dbl_done) begin
                    start = 1'b1; h_in = 32'h7; y0_in = 32'h5; n_in = 16'd9;
                    dbl_done = 1'b1;
                end
                f_bus.f_ack = (wait_cnt == delay);
                f_bus.f_val = (wait_cnt == delay) ? fv : 32'hDEAD_BEEF;
                wait_cnt++;
            end else begin
                f_bus.f_ack = 1'b0;
                wait_cnt = 0;
            end
            if (y_valid) begin
                $display("[TB] %s step %0d: y_out=%h t_out=%h", name, yv_cnt, y_out, t_out);
                if (yv_cnt < 3) begin
                    check({name, " y_out"}, y_out, ey[yv_cnt]);
                    check({name, " t_out"}, t_out, et[yv_cnt]);
                end
                if (yv_cnt > 0) check({name, " step latency"}, 64'(cyc - last_yv), 64'd3 + 64'(delay));
                last_yv = cyc;
                yv_cnt++;
            end
            if (final_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        f_bus.f_ack = 1'b0;

        for (int k = 0; k < 4; k++) begin
            if (final_done || y_valid || busy) extra++;
            @(posedge clk); #1;
        end

        check({name, " final_done seen"}, 64'(fd_cnt), 64'd1);
        check({name, " y_valid count"}, 64'(yv_cnt), 64'(nv));
        check({name, " activity after done"}, 64'(extra), 64'd0);
        if (nv == 16'd0) begin
            check({name, " f_req count"}, 64'(fr_seen), 64'd0);
            check({name, " done latency"}, 64'(fd_cyc), 64'd0);
        end else begin
            check({name, " done after last y_valid"}, 64'(fd_cyc - last_yv), 64'd1);
        end
        $display("[TB] %s: %0d steps, final_done at cycle %0d", name, yv_cnt, fd_cyc);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        h_in = '0; t0_in = '0; y0_in = '0; n_in = '0;
        f_bus.f_ack = 1'b0;
        f_bus.f_val = '0;

        @(posedge clk); @(posedge clk); #1;
        check("rst busy", busy, 1'b0);
        check("rst f_req", f_bus.f_req, 1'b0);
        check("rst y_valid", y_valid, 1'b0);
        check("rst final_done", final_done, 1'b0);
        check("rst y_out", y_out, 32'h0);
        check("rst t_out", t_out, 32'h0);
        check("rst f_t", f_bus.f_t, 32'h0);
        check("rst f_y", f_bus.f_y, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // h=0.5, f=1.0 from y=1.0: y 1.5,2.0,2.5 and t 0.5,1.0,1.5
        run_seq("basic", 32'h0000_8000, 32'h0, 32'h0001_0000, 16'd3, 0, 32'h0001_0000, 1'b0,
                32'h0001_8000, 32'h0002_0000, 32'h0002_8000,
                32'h0000_8000, 32'h0001_0000, 32'h0001_8000);

        run_seq("zero_steps", 32'h0000_8000, 32'h0, 32'h0001_0000, 16'd0, 0, 32'h0001_0000, 1'b0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // 0.5 * -2^-16 = -2^-17 floors to -1 LSB
        run_seq("slow_ack", 32'h0000_8000, 32'h0002_0000, 32'h0001_0000, 16'd1, 5, 32'hFFFF_FFFF, 1'b0,
                32'h0000_FFFF, 32'h0, 32'h0, 32'h0002_8000, 32'h0, 32'h0);

        run_seq("double_start", 32'h0001_0000, 32'h0, 32'h0, 16'd2, 0, 32'h0003_0000, 1'b1,
                32'h0003_0000, 32'h0006_0000, 32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0);

`ifdef EULER_SAT_EN
        run_seq("overflow", 32'h0001_0000, 32'h7FFF_8000, 32'h7FFF_0000, 16'd1, 0, 32'h0001_0000, 1'b0,
                32'h7FFF_FFFF, 32'h0, 32'h0, 32'h8000_8000, 32'h0, 32'h0);
`else
        run_seq("overflow", 32'h0001_0000, 32'h7FFF_8000, 32'h7FFF_0000, 16'd1, 0, 32'h0001_0000, 1'b0,
                32'h8000_0000, 32'h0, 32'h0, 32'h8000_8000, 32'h0, 32'h0);
`endif

        // Abort a run from MUL with an asynchronous reset.
        begin
            int guard;
            int fd_seen;
            guard = 0;
            fd_seen = 0;
            h_in = 32'h0000_8000; t0_in = 32'h0; y0_in = 32'h0001_0000; n_in = 16'd3;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            while (!f_bus.f_req && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            check("abort f_req reached", f_bus.f_req, 1'b1);
            f_bus.f_ack = 1'b1;
            f_bus.f_val = 32'h0001_0000;
            @(posedge clk); #1;
            f_bus.f_ack = 1'b0;
            check("abort in MUL busy", busy, 1'b1);
            check("abort in MUL f_req", f_bus.f_req, 1'b0);
            #1 rst_n = 1'b0;
            #1;
            check("abort busy", busy, 1'b0);
            check("abort f_req", f_bus.f_req, 1'b0);
            check("abort y_valid", y_valid, 1'b0);
            check("abort y_out", y_out, 32'h0);
            check("abort t_out", t_out, 32'h0);
            check("abort f_t", f_bus.f_t, 32'h0);
            check("abort f_y", f_bus.f_y, 32'h0);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                if (final_done) fd_seen++;
            end
            check("abort final_done", 64'(fd_seen), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            $display("[TB] abort: reset applied in MUL and released");
        end

        run_seq("after_abort", 32'h0000_8000, 32'h0, 32'h0001_0000, 16'd3, 0, 32'h0001_0000, 1'b0,
                32'h0001_8000, 32'h0002_0000, 32'h0002_8000,
                32'h0000_8000, 32'h0001_0000, 32'h0001_8000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
